switch_out_arbiter: RTL

Round-robin output-port arbiter and sequencer for one switch egress port, shared by the 8 switch ingress FIFOs (X side 0-3, Y side 0-3).
- Picks one requesting FIFO per packet.
- Pops that FIFO's head word.
- Registers it with its 3-bit source ID.
- Drives the device-side validrx/ackrx handshake.
- One instance per egress port inside the switch top.

---
 rtl/switch_out_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter
// Round-robin egress arbiter for one switch output port. Eight ingress FIFOs
// (X0-X3 on bits 0-3, Y0-Y3 on bits 4-7) compete for the port. For each packet
// one FIFO is granted, its head word is popped and registered together with
// its 3-bit source ID, and the word is offered to the device via validrx/ackrx.
//
// Optional build macro: SWARB_TIMEOUT_EN
//   defined   : a word not acknowledged within TMO SEND cycles is dropped and
//               err_o pulses for one cycle.
//   undefined : SEND waits for ackrx indefinitely; err_o is tied low.
module switch_out_arbiter #(
    parameter int DW  = 4,
    parameter int TMO = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      req_i,
    input  logic [8*DW-1:0] dat_i,
    output logic [7:0]      pop_o,
    output logic [7:0]      grant_o,
    output logic [DW+2:0]   dat_o,
    output logic            validrx,
    input  logic            ackrx,
    output logic            busy_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10
    } state_t;

    state_t          r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_g;
    logic [7:0]      r_grant;
    logic [DW+2:0]   r_dat;
    logic            r_valid;
    logic            r_busy;

    logic [3:0]      w_pick;
    logic [DW-1:0]   w_payload;
    logic [7:0]      w_pop;

`ifdef SWARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    logic [7:0]      r_cnt;
    logic            r_err;
`endif

    // Round-robin search: first set request bit starting at ptr, wrapping mod 8.
    // Returns {found, index}. Scanning from the far end lets the nearest hit win.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next owner candidate, evaluated against the current pointer.
    always_comb begin
        w_pick = rr_pick(req_i, r_ptr);
    end

    // Head word of the granted FIFO.
    always_comb begin
        w_payload = dat_i[r_g*DW +: DW];
    end

    // FIFO read strobe: only in LOAD and only while the owner still requests.
    always_comb begin
        w_pop = 8'h00;
        if ((r_state == ST_LOAD) && req_i[r_g]) begin
            w_pop[r_g] = 1'b1;
        end else begin
            w_pop = 8'h00;
        end
    end

    // Arbitration/sequencing FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_g     <= 3'd0;
            r_grant <= 8'h00;
            r_dat   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SWARB_TIMEOUT_EN
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
`endif
        end else begin
`ifdef SWARB_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_pick[3]) begin
                        r_g     <= w_pick[2:0];
                        r_grant <= 8'h01 << w_pick[2:0];
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (req_i[r_g]) begin
                        r_dat   <= {r_g, w_payload};
                        r_valid <= 1'b1;
                        r_state <= ST_SEND;
`ifdef SWARB_TIMEOUT_EN
                        r_cnt   <= 8'd0;
`endif
                    end else begin
                        // Request withdrawn before the pop: release, keep pointer.
                        r_grant <= 8'h00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (ackrx) begin
                        r_valid <= 1'b0;
                        r_grant <= 8'h00;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_g + 3'd1;
                        r_state <= ST_IDLE;
                    end else begin
`ifdef SWARB_TIMEOUT_EN
                        if (r_cnt == TMO_LAST) begin
                            // Device never answered: drop the word and move on.
                            r_valid <= 1'b0;
                            r_grant <= 8'h00;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                            r_ptr   <= r_g + 3'd1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                        end
`else
                        r_valid <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_grant <= 8'h00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop_o   = w_pop;
    assign grant_o = r_grant;
    assign dat_o   = r_dat;
    assign validrx = r_valid;
    assign busy_o  = r_busy;
`ifdef SWARB_TIMEOUT_EN
    assign err_o   = r_err;
`else
    assign err_o   = 1'b0;
`endif

endmodule
